mem_io_responder: RTL and testbench

MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

---
 rtl/bus_pkg.sv | 30 +++
 rtl/byte_fifo.sv | 58 +++++
 rtl/mem_io_responder.sv | 142 ++++++++++++++
 tb/tb_mem_io_responder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared byte-bus definitions: I/O window addresses, region code and the address decoder.
// The decoder looks at the 18-bit CPU address space only; higher address bits are don't-care.
package bus_pkg;

  localparam int          BUS_W        = 8;
  localparam logic [1:0]  IO_REGION    = 2'b11;
  localparam logic [17:0] IO_DATA_ADDR = 18'h30000;
  localparam logic [17:0] IO_CTRL_ADDR = 18'h30004;

  typedef logic [BUS_W-1:0] byte_t;

  typedef enum logic [2:0] {
    ACC_RAM,
    ACC_DATA,
    ACC_CTRL,
    ACC_CNT_HI,
    ACC_NONE
  } acc_e;

  function automatic acc_e decode(input logic [17:0] a);
    acc_e r;
    if (a[17:16] != IO_REGION)                               r = ACC_RAM;
    else if (a == IO_DATA_ADDR)                              r = ACC_DATA;
    else if (a == IO_CTRL_ADDR)                              r = ACC_CTRL;
    else if (a[17:2] == IO_CTRL_ADDR[17:2] && a[1:0] != '0)  r = ACC_CNT_HI;
    else                                                     r = ACC_NONE;
    return r;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO, power-of-two depth; head is visible on dout_o while not empty.
// Push into a full FIFO is dropped; pop of an empty FIFO is ignored; push+pop keeps count.
module byte_fifo
  import bus_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  byte_t         din_i,
  input  logic          pop_i,
  output byte_t         dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  byte_t         mem_q [0:DEPTH-1];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage is not reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/mem_io_responder.sv
// CPU byte-memory responder: RAM below the 0x3xxxx I/O window, TX/RX byte streams at 0x30000, stop at 0x30004.
// Define CLK_COUNTER_EN to add the 32-bit cycle counter snapshot readable at 0x30004..0x30007.
module mem_io_responder
  import bus_pkg::*;
#(
  parameter int RAM_ADDR_W = 17,
  parameter int TX_DEPTH   = 8,
  parameter int RX_DEPTH   = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        rdy_out,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        prog_stop
);

  localparam int          TXW      = $clog2(TX_DEPTH);
  localparam int          RXW      = $clog2(RX_DEPTH);
  localparam logic [TXW:0] TX_HIWAT = (TXW+1)'(TX_DEPTH - 1);

  byte_t                 ram_q [0:(1<<RAM_ADDR_W)-1];
  logic [RAM_ADDR_W-1:0] ram_idx;
  acc_e                  acc;
  byte_t                 din_q, din_d;
  logic                  rdy_q, rdy_d, stop_q, stop_d;
  logic                  wr_ok, rd_ok, ram_we;
  logic                  tx_push, tx_pop, tx_full, tx_empty;
  logic                  rx_push, rx_pop, rx_full, rx_empty;
  byte_t                 tx_push_dat, rx_head;
  logic [TXW:0]          tx_cnt;
  logic [RXW:0]          rx_cnt;
  logic                  unused_misc;

`ifdef CLK_COUNTER_EN
  logic [31:0] cyc_q, snap_q;
`endif

  assign ram_idx = mem_a[RAM_ADDR_W-1:0];
  assign acc     = decode(mem_a[17:0]);

  // While frozen (rdy low) the bus is ignored entirely; after a stop only reads proceed.
  assign wr_ok  = rdy_q && mem_wr && !stop_q;
  assign rd_ok  = rdy_q && !mem_wr;
  assign ram_we = wr_ok && (acc == ACC_RAM);

  assign tx_push     = wr_ok && ((acc == ACC_DATA && mem_dout != '0) || acc == ACC_CTRL);
  assign tx_push_dat = (acc == ACC_CTRL) ? byte_t'(0) : mem_dout;
  assign tx_pop      = tx_valid && tx_ready;
  assign rx_push     = rx_valid && rx_ready;
  assign rx_pop      = rd_ok && (acc == ACC_DATA) && !rx_empty;

  assign tx_valid  = !tx_empty;
  assign rx_ready  = !rx_full;
  assign mem_din   = din_q;
  assign rdy_out   = rdy_q;
  assign prog_stop = stop_q;

  always_comb begin
    din_d = din_q;
    if (rd_ok) begin
      unique case (acc)
        ACC_RAM:    din_d = ram_q[ram_idx];
        ACC_DATA:   din_d = rx_empty ? byte_t'(0) : rx_head;
`ifdef CLK_COUNTER_EN
        ACC_CTRL:   din_d = cyc_q[7:0];
        ACC_CNT_HI: din_d = snap_q[{mem_a[1:0], 3'b000} +: 8];
`else
        ACC_CTRL:   din_d = '0;
        ACC_CNT_HI: din_d = '0;
`endif
        default:    din_d = '0;
      endcase
    end
    stop_d = stop_q || (wr_ok && acc == ACC_CTRL);
    // Registered from the current count, leaving one slot for a write already in flight.
    rdy_d  = (tx_cnt < TX_HIWAT);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      din_q  <= '0;
      rdy_q  <= 1'b1;
      stop_q <= 1'b0;
    end else begin
      din_q  <= din_d;
      rdy_q  <= rdy_d;
      stop_q <= stop_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (ram_we) ram_q[ram_idx] <= mem_dout;
  end

`ifdef CLK_COUNTER_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cyc_q  <= '0;
      snap_q <= '0;
    end else begin
      cyc_q <= cyc_q + 1'b1;
      if (rd_ok && acc == ACC_CTRL) snap_q <= cyc_q;
    end
  end
`endif

  byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .push_i  (tx_push),
    .din_i   (tx_push_dat),
    .pop_i   (tx_pop),
    .dout_o  (tx_data),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_cnt)
  );

  byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .push_i  (rx_push),
    .din_i   (rx_data),
    .pop_i   (rx_pop),
    .dout_o  (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_cnt)
  );

  assign unused_misc = ^{mem_a[31:18], rx_cnt, tx_full};

endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder: directed CPU/RX stimulus, expected reads and TX bytes queued
// at issue time and popped by independent monitors when the DUT presents them.
module tb_mem_io_responder;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic [31:0] mem_a = '0;
  logic        mem_wr = 1'b0;
  logic [7:0]  mem_dout = '0;
  logic [7:0]  mem_din;
  logic        rdy_out;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        prog_stop;

  int checks = 0;
  int failures = 0;

  logic [7:0] rd_exp[$];
  string      rd_name[$];
  logic [7:0] tx_exp[$];
  logic       rd_en = 1'b0;
  logic       rd_pend = 1'b0;

  always #5 clk = ~clk;

  mem_io_responder dut (
    .clk_in    (clk),
    .rst_in    (rst_in),
    .mem_a     (mem_a),
    .mem_wr    (mem_wr),
    .mem_dout  (mem_dout),
    .mem_din   (mem_din),
    .rdy_out   (rdy_out),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .prog_stop (prog_stop)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Read-data monitor: one cycle after a read is sampled, mem_din must hold the queued value.
  always @(posedge clk) rd_pend <= rd_en;

  always @(negedge clk) begin
    if (rd_pend) begin
      if (rd_exp.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected actual=0x%0h required=none", mem_din);
      end else begin
        string      nm;
        logic [7:0] ev;
        nm = rd_name.pop_front();
        ev = rd_exp.pop_front();
        check(nm, {24'h0, mem_din}, {24'h0, ev});
      end
    end
  end

  // TX monitor: every accepted byte must match the head of the expected stream.
  always @(negedge clk) begin
    if (!rst_in && tx_valid === 1'b1 && tx_ready) begin
      if (tx_exp.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL tx_unexpected actual=0x%0h required=none", tx_data);
      end else begin
        logic [7:0] ev;
        ev = tx_exp.pop_front();
        check("tx_byte", {24'h0, tx_data}, {24'h0, ev});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [7:0] d);
    mem_a = a; mem_wr = 1'b1; mem_dout = d;
    tick();
    mem_wr = 1'b0; mem_a = '0; mem_dout = '0;
  endtask

  task automatic cpu_read(input logic [31:0] a, input logic [7:0] exp, input string name);
    mem_a = a; mem_wr = 1'b0; rd_en = 1'b1;
    rd_exp.push_back(exp);
    rd_name.push_back(name);
    tick();
    rd_en = 1'b0; mem_a = '0;
  endtask

  task automatic rx_send(input logic [7:0] d);
    rx_data = d; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx_idle(input int max, input string name);
    int n = 0;
    while (tx_valid && n < max) begin
      tick();
      n++;
    end
    checks++;
    if (tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s actual=tx_valid_%0b required=drained_in_%0d", name, tx_valid, max);
    end
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    tick();
    tick();
    rst_in = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    rst_in = 1'b1;
    tick();
    tick();
    check("rst_mem_din",   mem_din,   0);
    check("rst_rdy_out",   rdy_out,   1);
    check("rst_tx_valid",  tx_valid,  0);
    check("rst_rx_ready",  rx_ready,  1);
    check("rst_prog_stop", prog_stop, 0);
    rst_in = 1'b0;

    // RAM write then immediate read-back, top address, and region aliasing
    cpu_write(32'h00010, 8'hA5);
    cpu_read (32'h00010, 8'hA5, "ram_a5");
    cpu_write(32'h1FFFF, 8'h5A);
    cpu_read (32'h1FFFF, 8'h5A, "ram_top");
    cpu_write(32'h20010, 8'h77);
    cpu_read (32'h00010, 8'h77, "ram_alias");
    cpu_write(32'h00020, 8'h11);

    // Undefined I/O and (default build) counter window read as zero
    tx_ready = 1'b1;
    cpu_write(32'h30008, 8'h99);
    cpu_read (32'h30008, 8'h00, "io_undef_08");
    cpu_read (32'h30001, 8'h00, "io_undef_01");
`ifndef CLK_COUNTER_EN
    cpu_read (32'h30004, 8'h00, "cnt_off_b0");
    cpu_read (32'h30007, 8'h00, "cnt_off_b3");
`endif

    // TX with consumer ready: push and pop overlap
    tx_exp.push_back(8'h42);
    cpu_write(32'h30000, 8'h42);
    tx_exp.push_back(8'h43);
    cpu_write(32'h30000, 8'h43);
    wait_tx_idle(20, "tx_drain_ready");

    // RX stream through the data port, empty read returns zero
    check("rx_ready_idle", rx_ready, 1);
    rx_send(8'h31);
    rx_send(8'h32);
    cpu_read(32'h30000, 8'h31, "rx_first");
    cpu_read(32'h30000, 8'h32, "rx_second");
    cpu_read(32'h30000, 8'h00, "rx_empty");

    // RX full: eight accepted, ninth refused
    for (int i = 0; i < 8; i++) rx_send(8'h80 + 8'(i));
    check("rx_ready_full", rx_ready, 0);
    rx_send(8'hFF);
    for (int i = 0; i < 8; i++) cpu_read(32'h30000, 8'h80 + 8'(i), "rx_full_drain");
    cpu_read(32'h30000, 8'h00, "rx_after_drain");

    // Push on an empty RX FIFO in the same cycle as a data-port read
    rx_data = 8'h11; rx_valid = 1'b1;
    cpu_read(32'h30000, 8'h00, "rx_same_cycle");
    rx_valid = 1'b0;
    cpu_read(32'h30000, 8'h11, "rx_after_same");

    // TX backpressure: zero write ignored, seventh push freezes the CPU
    tx_ready = 1'b0;
    cpu_write(32'h30000, 8'h00);
    for (int i = 1; i <= 7; i++) begin
      cpu_write(32'h30000, 8'h41);
      tx_exp.push_back(8'h41);
      if (i >= 6) check("rdy_before_drop", rdy_out, 1);
    end
    tick();
    check("rdy_low_after_7", rdy_out, 0);
    cpu_write(32'h00010, 8'hEE);
    check("rdy_still_low", rdy_out, 0);
    check("tx_valid_held", tx_valid, 1);
    tx_ready = 1'b1;
    wait_tx_idle(30, "tx_drain_7");
    tick();
    check("rdy_recovered", rdy_out, 1);
    cpu_read(32'h00010, 8'h77, "frozen_write_ignored");

    // Program stop: zero byte queued, later writes ignored
    tx_exp.push_back(8'h00);
    cpu_write(32'h30004, 8'h7E);
    check("prog_stop_set", prog_stop, 1);
    cpu_write(32'h00020, 8'hBB);
    cpu_write(32'h30000, 8'h55);
    cpu_read (32'h00020, 8'h11, "ram_after_stop");
    wait_tx_idle(20, "tx_drain_stop");
    check("prog_stop_sticky", prog_stop, 1);

    // Reset mid-transfer with queued TX bytes and stop set
    do_reset();
    tx_ready = 1'b0;
    cpu_write(32'h30000, 8'h61);
    cpu_write(32'h30000, 8'h62);
    cpu_write(32'h30000, 8'h63);
    cpu_write(32'h30004, 8'h00);
    check("tx_queued", tx_valid, 1);
    check("stop_before_rst", prog_stop, 1);
    cpu_read(32'h00010, 8'h77, "pre_rst_read");
    rst_in = 1'b1;
    tick();
    check("rst2_tx_valid",  tx_valid,  0);
    check("rst2_rdy_out",   rdy_out,   1);
    check("rst2_prog_stop", prog_stop, 0);
    check("rst2_mem_din",   mem_din,   0);
    tx_exp.delete();
    tick();
    rst_in = 1'b0;
    tx_ready = 1'b1;
    repeat (3) tick();
    cpu_read(32'h00010, 8'h77, "ram_kept_over_rst");

`ifdef CLK_COUNTER_EN
    // Counter: first non-reset edge makes it 1, so the read sampled on edge 101 sees 100
    do_reset();
    repeat (100) tick();
    cpu_read(32'h30004, 8'h64, "cnt_b0");
    cpu_read(32'h30005, 8'h00, "cnt_b1");
    cpu_read(32'h30006, 8'h00, "cnt_b2");
    cpu_read(32'h30007, 8'h00, "cnt_b3");
    cpu_read(32'h30004, 8'h68, "cnt_resnap_b0");
`endif

    repeat (4) tick();
    check("rd_queue_empty", rd_exp.size(), 0);
    check("tx_queue_empty", tx_exp.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
